// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with valid/ready handshake.
// Single-cycle ops: ADD, SUB, AND, OR, SLT. Unsupported codes complete with Illegal=1.
// Optional multiplier, enabled by the ALU_EXEC_MUL_EN macro: a shift-add unit
// that retires one multiplier bit per cycle over WIDTH cycles.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_CNTL,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Illegal,
    output logic             Busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             accept;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_step;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign Busy     = (state_q == MUL);
`else
    // Without the multiplier there is only an idle state, so no state register.
    assign in_ready = !out_valid_q || out_ready;
    assign Busy     = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;

    // Single-cycle datapath; unsupported codes yield a zero result and the illegal flag.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ALU_CNTL)
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state: output hold/consume, single-cycle retire, multiply iteration.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
        if (state_q == MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Last multiplier bit: retire the product straight from the adder.
            if (cnt_q == CW'(WIDTH-1)) begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                result_d    = acc_step;
                zero_d      = (acc_step == '0);
                illegal_d   = 1'b0;
            end
        end else if (accept && ALU_CNTL == OP_MUL) begin
            state_d  = MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = SrcA;
            mplier_d = SrcB;
        end else
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            illegal_d   = alu_ill;
        end
    end

    // State registers with asynchronous reset; reset also aborts a multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage (WIDTH=32). Inputs change 1ns after a
// rising edge; outputs are sampled at that same point.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALU_CNTL;
    logic [31:0] SrcA, SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero, Illegal, Busy;

    int checks = 0;
    int errors = 0;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_CNTL(ALU_CNTL), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Zero(Zero), .Illegal(Illegal),
        .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge, then drop in_valid.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ALU_CNTL = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALU_CNTL = 3'b000; SrcA = '0; SrcB = '0;
        #2;
        checks++;
        if ({out_valid, Result, Zero, Illegal, Busy} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b res=%h z=%b ill=%b busy=%b, want all 0",
                     out_valid, Result, Zero, Illegal, Busy);
        end
        step(); step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
        checks++;
        if ({out_valid, Result, Zero, Illegal} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_wrap: got vld=%b res=%h z=%b ill=%b, want 1 00000000 1 0",
                     out_valid, Result, Zero, Illegal);
        end
        issue(3'b000, 32'd3, 32'd4);
        checks++;
        if ({Result, Zero} !== {32'd7, 1'b0}) begin
            errors++;
            $display("FAIL add_3_4: got res=%h z=%b want 00000007 0", Result, Zero);
        end
    endtask

    task automatic test_sub_slt();
        out_ready = 1'b1;
        issue(3'b101, 32'h8000_0000, 32'h0000_0001);
        checks++;
        if ({Result, Zero, Illegal} !== {32'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL slt_neg: got res=%h z=%b ill=%b want 00000001 0 0", Result, Zero, Illegal);
        end
        issue(3'b101, 32'h0000_0001, 32'h8000_0000);
        checks++;
        if ({Result, Zero} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL slt_pos: got res=%h z=%b want 00000000 1", Result, Zero);
        end
        issue(3'b101, 32'h7FFF_FFFF, 32'h8000_0000);
        checks++;
        if (Result !== 32'd0) begin
            errors++;
            $display("FAIL slt_ovf: got res=%h want 00000000", Result);
        end
        issue(3'b001, 32'd5, 32'd7);
        checks++;
        if ({Result, Zero, out_valid} !== {32'hFFFF_FFFE, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_5_7: got res=%h z=%b vld=%b want fffffffe 0 1", Result, Zero, out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(3'b110, 32'h1234_5678, 32'h1);
        checks++;
        if ({out_valid, Result, Zero, Illegal} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_110: got vld=%b res=%h z=%b ill=%b want 1 0 1 1",
                     out_valid, Result, Zero, Illegal);
        end
        issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if ({Result, Zero, Illegal} !== {32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_111: got res=%h z=%b ill=%b want 0 1 1", Result, Zero, Illegal);
        end
        issue(3'b010, 32'hFF, 32'h0F);
        checks++;
        if ({Result, Illegal} !== {32'h0F, 1'b0}) begin
            errors++;
            $display("FAIL illegal_clears: got res=%h ill=%b want 0000000f 0", Result, Illegal);
        end
`ifndef ALU_EXEC_MUL_EN
        issue(3'b100, 32'd12, 32'd13);
        checks++;
        if ({out_valid, Result, Zero, Illegal, Busy} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mul_disabled: got vld=%b res=%h z=%b ill=%b busy=%b want 1 0 1 1 0",
                     out_valid, Result, Zero, Illegal, Busy);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int rdy_low = 0;
        out_ready = 1'b1;
        ALU_CNTL = 3'b010; SrcA = 32'hF0F0_F0F0; SrcB = 32'h0FF0_0FF0; in_valid = 1'b1;
        if (in_ready !== 1'b1) rdy_low++;
        step();
        checks++;
        if ({out_valid, Result} !== {1'b1, 32'h00F0_00F0}) begin
            errors++;
            $display("FAIL b2b_and: got vld=%b res=%h want 1 00f000f0", out_valid, Result);
        end
        ALU_CNTL = 3'b011;
        if (in_ready !== 1'b1) rdy_low++;
        step();
        checks++;
        if ({out_valid, Result} !== {1'b1, 32'hFFF0_FFF0}) begin
            errors++;
            $display("FAIL b2b_or: got vld=%b res=%h want 1 fff0fff0", out_valid, Result);
        end
        checks++;
        if (rdy_low != 0) begin
            errors++;
            $display("FAIL b2b_in_ready: low on %0d cycles, want 0", rdy_low);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_clear: got vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        out_ready = 1'b0;
        issue(3'b000, 32'd1, 32'd2);
        ALU_CNTL = 3'b000; SrcA = 32'd10; SrcB = 32'd20; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || Result !== 32'd3) bad++;
            step();
        end
        checks++;
        if (bad != 0 || Result !== 32'd3) begin
            errors++;
            $display("FAIL hold_stall: %0d bad cycles, res=%h want 0 and 00000003", bad, Result);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, Result} !== {1'b1, 32'd30}) begin
            errors++;
            $display("FAIL hold_new_result: got vld=%b res=%h want 1 0000001e", out_valid, Result);
        end
        step();
    endtask

`ifdef ALU_EXEC_MUL_EN
    task automatic test_mul();
        int busy_cnt = 0;
        int early = 0;
        int late_vld = 0;
        out_ready = 1'b1;
        issue(3'b100, 32'd12, 32'd13);
        checks++;
        if ({Busy, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mul_busy_start: got busy=%b rdy=%b want 1 0", Busy, in_ready);
        end
        for (int k = 1; k <= 32; k++) begin
            if (Busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1) early++;
            step();
        end
        checks++;
        if (busy_cnt != 32 || early != 0) begin
            errors++;
            $display("FAIL mul_busy_cycles: got busy=%0d early_vld=%0d want 32 0", busy_cnt, early);
        end
        checks++;
        if ({out_valid, Result, Zero, Illegal, Busy} !== {1'b1, 32'd156, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul_12_13: got vld=%b res=%h z=%b ill=%b busy=%b want 1 0000009c 0 0 0",
                     out_valid, Result, Zero, Illegal, Busy);
        end
        issue(3'b100, 32'd7, 32'd9);
        for (int k = 1; k < 10; k++) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, Result, Zero, Illegal, Busy} !== 36'h0) begin
            errors++;
            $display("FAIL mul_abort_reset: got vld=%b res=%h z=%b ill=%b busy=%b want all 0",
                     out_valid, Result, Zero, Illegal, Busy);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid !== 1'b0 || Busy !== 1'b0) late_vld++;
            step();
        end
        checks++;
        if (late_vld != 0) begin
            errors++;
            $display("FAIL mul_abort_no_result: %0d cycles with vld/busy, want 0", late_vld);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_illegal();
        test_back_to_back();
        test_hold();
`ifdef ALU_EXEC_MUL_EN
        test_mul();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  stage can accept a request this cycle.
REQ-006 SHALL have port ALU_CNTL  input  3  operation code from the ALU decoder.
REQ-007 SHALL have ports SrcA, SrcB  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  Result/Zero/Illegal hold a completed operation.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port Result  output  WIDTH  registered operation result.
REQ-011 SHALL have port Zero  output  1  registered flag, high when Result == 0.
REQ-012 SHALL have port Illegal  output  1  registered flag, high when the accepted code was unsupported.
REQ-013 SHALL have port Busy  output  1  high while a multi-cycle operation iterates.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both high; SrcA, SrcB, ALU_CNTL are sampled only then.
REQ-015 SHALL drive in_ready = (state == IDLE) and (out_valid == 0 or out_ready == 1).
REQ-016 SHALL implement codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; ADD/SUB wrap modulo 2^WIDTH.
REQ-017 SLT SHALL return 1 when SrcA < SrcB as two's-complement signed values (overflow-correct), else 0, zero-extended to WIDTH.
REQ-018 Single-cycle codes SHALL update Result, Zero, Illegal=0 and set out_valid on the edge after acceptance (latency 1).
REQ-019 Unsupported codes (110, 111, and 100 when multiply is compiled out) SHALL complete with latency 1, Result = 0, Zero = 1, Illegal = 1.
REQ-020 out_valid and result registers SHALL hold unchanged while out_valid = 1 and out_ready = 0.
REQ-021 On an edge with out_valid = 1, out_ready = 1 and no new acceptance, out_valid SHALL clear.
REQ-022 On an edge with out_ready = 1 and a simultaneous acceptance of a single-cycle op, the new result SHALL replace the old and out_valid SHALL stay 1 (back-to-back throughput 1/cycle).
REQ-023 State machine SHALL have states IDLE and MUL; IDLE->MUL on acceptance of code 100 (multiply compiled in); MUL->IDLE after the final iteration; all other acceptances stay in IDLE.
REQ-024 In MUL, Busy SHALL be 1 and in_ready 0; the accepted previous result SHALL remain held until consumed.
REQ-025 Zero SHALL always be computed from the value loaded into Result.

Reset
REQ-026 Asserting rst SHALL asynchronously force state IDLE, out_valid 0, Result 0, Zero 0, Illegal 0, Busy 0, iteration counter 0.
REQ-027 rst asserted during MUL SHALL abort the multiply; no result SHALL be produced after rst releases.
REQ-028 in_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-029 Macro ALU_EXEC_MUL_EN SHALL control the multiplier.
REQ-030 With ALU_EXEC_MUL_EN defined, code 100 SHALL be MUL: shift-add, one bit per cycle, WIDTH iterations, Result = low WIDTH bits of unsigned SrcA*SrcB, out_valid set on the WIDTH-th edge after acceptance, Illegal = 0.
REQ-031 Without ALU_EXEC_MUL_EN, code 100 SHALL be unsupported per REQ-019, state MUL SHALL not exist, and Busy SHALL be constant 0.

Verification
REQ-032 ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> next edge out_valid=1, Result=0x00000000, Zero=1, Illegal=0.
REQ-033 SLT SrcA=0x80000000, SrcB=0x00000001 -> Result=1; SUB 5-7 -> Result=0xFFFFFFFE, Zero=0.
REQ-034 Back-to-back AND 0xF0F0F0F0&0x0FF00FF0, then OR same operands, out_ready=1 -> Result 0x00F000F0 then 0xFFF0FFF0 on consecutive edges, in_ready never low.
REQ-035 Result pending, out_ready=0 for 3 cycles, new in_valid -> in_ready=0, Result unchanged; out_ready=1 -> new request accepted same edge.
REQ-036 ALU_EXEC_MUL_EN defined: MUL 12*13 -> Busy=1 for 32 cycles, Result=156 on edge 32; rst at cycle 10 of another MUL -> all outputs 0, no out_valid afterward; macro undefined: code 100 -> Illegal=1, Result=0.
